// File: rtl/seq_pkg.sv
// Shared types for the multicycle sequencer: state and opcode encodings,
// plus the position of the opcode field inside the 9-bit instruction.
package seq_pkg;

  localparam int INSTR_W = 9;
  localparam int OPC_LSB = 1;
  localparam int OPC_W   = 4;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALTED = 3'd6,
    S_BAD    = 3'd7
  } state_t;

  typedef enum logic [3:0] {
    OP_LDI  = 4'h0,
    OP_LDM  = 4'h1,
    OP_ST   = 4'h2,
    OP_ALU3 = 4'h3,
    OP_ALU4 = 4'h4,
    OP_ALU5 = 4'h5,
    OP_ALU6 = 4'h6,
    OP_ALU7 = 4'h7,
    OP_JUMP = 4'h8,
    OP_BEQ  = 4'h9,
    OP_BLT  = 4'hA,
    OP_BGT  = 4'hB,
    OP_LS   = 4'hC,
    OP_RS   = 4'hD,
    OP_NOP  = 4'hE,
    OP_HALT = 4'hF
  } opcode_t;

endpackage

// File: rtl/seq_perf_counters.sv
// Saturating busy-cycle and retired-fetch counters for the sequencer.
// Only instantiated when SEQ_PERF_CNT_EN is defined.
module seq_perf_counters (
  input  logic        clk,
  input  logic        reset,
  input  logic        clr_i,
  input  logic        busy_i,
  input  logic        fetch_i,
  output logic [31:0] cycle_cnt_o,
  output logic [31:0] instr_cnt_o
);

  logic [31:0] cycle_cnt_q, cycle_cnt_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;

  always_comb begin
    cycle_cnt_d = cycle_cnt_q;
    instr_cnt_d = instr_cnt_q;
    if (clr_i) begin
      cycle_cnt_d = '0;
      instr_cnt_d = '0;
    end else begin
      if (busy_i && (cycle_cnt_q != '1)) cycle_cnt_d = cycle_cnt_q + 32'd1;
      if (fetch_i && (instr_cnt_q != '1)) instr_cnt_d = instr_cnt_q + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cycle_cnt_q <= '0;
      instr_cnt_q <= '0;
    end else begin
      cycle_cnt_q <= cycle_cnt_d;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign cycle_cnt_o = cycle_cnt_q;
  assign instr_cnt_o = instr_cnt_q;

endmodule

// File: rtl/multicycle_sequencer.sv
// FETCH/DECODE/EXEC/MEM/WB sequencer owning PC and IR for the 9-bit core.
// Define SEQ_PERF_CNT_EN to add cycle_cnt/instr_cnt performance outputs.
module multicycle_sequencer
  import seq_pkg::*;
#(
  parameter int          PC_W     = 8,
  parameter int unsigned START_PC = 0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic [8:0]         instr_in,
  input  logic               branch_flag,
  input  logic               mem_to_reg,
  input  logic               mem_write,
  input  logic               reg_write,
  input  logic               alu_cond,
  input  logic [PC_W-1:0]    branch_target,
  output logic [PC_W-1:0]    pc,
  output logic [8:0]         ir,
  output logic               ir_load,
  output logic               rf_we,
  output logic               mem_we,
  output logic               mem_re,
  output logic               wb_sel_mem,
  output logic               busy,
  output logic               done,
  output logic [2:0]         state_o
`ifdef SEQ_PERF_CNT_EN
  ,
  output logic [31:0]        cycle_cnt,
  output logic [31:0]        instr_cnt
`endif
);

  localparam logic [PC_W-1:0] START_VAL = PC_W'(START_PC);

  state_t          state_q, state_d;
  logic [PC_W-1:0] pc_q, pc_d, pc_inc;
  logic [8:0]      ir_q, ir_d;
  opcode_t         opc;
  logic            start_ok;
  logic            ir_load_c, rf_we_c, mem_we_c, mem_re_c, wb_sel_c, done_c;

  assign opc    = opcode_t'(ir_q[OPC_LSB +: OPC_W]);
  assign pc_inc = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    start_ok  = 1'b0;
    ir_load_c = 1'b0;
    rf_we_c   = 1'b0;
    mem_we_c  = 1'b0;
    mem_re_c  = 1'b0;
    wb_sel_c  = 1'b0;
    done_c    = 1'b0;
    case (state_q)
      S_IDLE, S_HALTED: begin
        if (start) begin
          start_ok = 1'b1;
          pc_d     = START_VAL;
          state_d  = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_load_c = 1'b1;
        ir_d      = instr_in;
        state_d   = S_DECODE;
      end
      S_DECODE: begin
        if (opc == OP_HALT) begin
          done_c  = 1'b1;
          state_d = S_HALTED;
        end else begin
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        // Branch flag wins over any memory/register flags raised alongside it.
        if (branch_flag) begin
          pc_d    = ((opc == OP_JUMP) || alu_cond) ? branch_target : pc_inc;
          state_d = S_FETCH;
        end else if (mem_write || mem_to_reg) begin
          state_d = S_MEM;
        end else if (reg_write) begin
          state_d = S_WB;
        end else begin
          pc_d    = pc_inc;
          state_d = S_FETCH;
        end
      end
      S_MEM: begin
        if (mem_write) begin
          mem_we_c = 1'b1;
          pc_d     = pc_inc;
          state_d  = S_FETCH;
        end else begin
          mem_re_c = 1'b1;
          state_d  = S_WB;
        end
      end
      S_WB: begin
        rf_we_c  = 1'b1;
        wb_sel_c = mem_to_reg;
        pc_d     = pc_inc;
        state_d  = S_FETCH;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      pc_q    <= START_VAL;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
    end
  end

  // Strobes come straight from state, so they must be masked while reset
  // is asserted mid-instruction.
  assign ir_load    = ir_load_c & ~reset;
  assign rf_we      = rf_we_c   & ~reset;
  assign mem_we     = mem_we_c  & ~reset;
  assign mem_re     = mem_re_c  & ~reset;
  assign wb_sel_mem = wb_sel_c  & ~reset;
  assign done       = done_c    & ~reset;
  assign busy       = (state_q != S_IDLE) && (state_q != S_HALTED) && !reset;
  assign pc         = pc_q;
  assign ir         = ir_q;
  assign state_o    = state_q;

`ifdef SEQ_PERF_CNT_EN
  seq_perf_counters u_perf (
    .clk         (clk),
    .reset       (reset),
    .clr_i       (start_ok),
    .busy_i      (busy),
    .fetch_i     (ir_load),
    .cycle_cnt_o (cycle_cnt),
    .instr_cnt_o (instr_cnt)
  );
`endif

endmodule

// File: tb/tb_multicycle_sequencer.sv
// Directed bench: program ROM plus a tiny Control decoder around two sequencer
// instances (PC_W=8 from 0, and PC_W=4 starting at 4'hF to exercise PC wrap).
module tb_multicycle_sequencer;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  // {branch, mem_to_reg, mem_write, reg_write}
  function automatic logic [3:0] ctl(input logic [8:0] i);
    logic [3:0] op;
    op = i[4:1];
    case (op)
      4'h0, 4'h3, 4'h4, 4'h5, 4'h6, 4'h7, 4'hC, 4'hD: ctl = 4'b0001;
      4'h1:                                           ctl = 4'b0101;
      4'h2:                                           ctl = 4'b0010;
      4'h8, 4'h9, 4'hA, 4'hB:                         ctl = 4'b1000;
      default:                                        ctl = 4'b0000;
    endcase
  endfunction

  // ---------------- instance A: PC_W=8, START_PC=0
  logic [8:0] rom_a [256];
  logic       start_a = 1'b0, cond_a = 1'b0;
  logic [7:0] tgt_a = 8'h00;
  logic [7:0] pc_a;
  logic [8:0] ir_a;
  logic       br_a, m2r_a, mw_a, rw_a;
  logic       irl_a, rf_a, mwe_a, mre_a, wbs_a, busy_a, done_a;
  logic [2:0] st_a;
  assign {br_a, m2r_a, mw_a, rw_a} = ctl(ir_a);
`ifdef SEQ_PERF_CNT_EN
  logic [31:0] cyc_a, ins_a, cyc_b, ins_b;
`endif

  multicycle_sequencer #(.PC_W(8), .START_PC(0)) dut_a (
    .clk(clk), .reset(reset), .start(start_a), .instr_in(rom_a[pc_a]),
    .branch_flag(br_a), .mem_to_reg(m2r_a), .mem_write(mw_a), .reg_write(rw_a),
    .alu_cond(cond_a), .branch_target(tgt_a), .pc(pc_a), .ir(ir_a),
    .ir_load(irl_a), .rf_we(rf_a), .mem_we(mwe_a), .mem_re(mre_a),
    .wb_sel_mem(wbs_a), .busy(busy_a), .done(done_a), .state_o(st_a)
`ifdef SEQ_PERF_CNT_EN
    , .cycle_cnt(cyc_a), .instr_cnt(ins_a)
`endif
  );

  // ---------------- instance B: PC_W=4, START_PC=15
  logic [8:0] rom_b [16];
  logic       start_b = 1'b0;
  logic [3:0] pc_b;
  logic [8:0] ir_b;
  logic       br_b, m2r_b, mw_b, rw_b;
  logic       irl_b, rf_b, mwe_b, mre_b, wbs_b, busy_b, done_b;
  logic [2:0] st_b;
  assign {br_b, m2r_b, mw_b, rw_b} = ctl(ir_b);

  multicycle_sequencer #(.PC_W(4), .START_PC(15)) dut_b (
    .clk(clk), .reset(reset), .start(start_b), .instr_in(rom_b[pc_b]),
    .branch_flag(br_b), .mem_to_reg(m2r_b), .mem_write(mw_b), .reg_write(rw_b),
    .alu_cond(1'b0), .branch_target(4'h3), .pc(pc_b), .ir(ir_b),
    .ir_load(irl_b), .rf_we(rf_b), .mem_we(mwe_b), .mem_re(mre_b),
    .wb_sel_mem(wbs_b), .busy(busy_b), .done(done_b), .state_o(st_b)
`ifdef SEQ_PERF_CNT_EN
    , .cycle_cnt(cyc_b), .instr_cnt(ins_b)
`endif
  );

  // Pulse start on A, then record (as cycle numbers after the start edge)
  // where each strobe fires; stops one cycle after done, i.e. in HALTED.
  task automatic run_a(input int maxc, output int rf_c, output int rf_n,
                       output int re_c, output int we_c, output int dn_c,
                       output logic wbs, output int multi);
    rf_c = 0; rf_n = 0; re_c = 0; we_c = 0; dn_c = 0; wbs = 1'b0; multi = 0;
    @(negedge clk) start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    for (int k = 1; k <= maxc; k++) begin
      if (rf_a) begin
        rf_n++;
        if (rf_c == 0) begin rf_c = k; wbs = wbs_a; end
      end
      if (mre_a) re_c = k;
      if (mwe_a) we_c = k;
      if ((int'(rf_a) + int'(mre_a) + int'(mwe_a)) > 1) multi++;
      if (done_a) begin dn_c = k; break; end
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
  endtask

  int   rf_c, rf_n, re_c, we_c, dn_c, multi;
  logic wbs;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    for (int i = 0; i < 256; i++) rom_a[i] = 9'h01E;
    for (int i = 0; i < 16; i++)  rom_b[i] = 9'h01E;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    chk("rst_state", 32'(st_a), 32'd0);
    chk("rst_pc",    32'(pc_a), 32'd0);
    chk("rst_ir",    32'(ir_a), 32'd0);
    chk("rst_busy",  32'(busy_a), 32'd0);
    chk("rst_done",  32'(done_a), 32'd0);
    chk("rst_strb",  32'({irl_a, rf_a, mwe_a, mre_a, wbs_a}), 32'd0);
    chk("rst_pc_b",  32'(pc_b), 32'hF);
    reset = 1'b0;

    // add; halt
    rom_a[0] = 9'h006; rom_a[1] = 9'h01E;
    run_a(20, rf_c, rf_n, re_c, we_c, dn_c, wbs, multi);
    chk("add_rf_cyc",  32'(rf_c), 32'd4);
    chk("add_rf_cnt",  32'(rf_n), 32'd1);
    chk("add_wbsel",   32'(wbs), 32'd0);
    chk("add_done",    32'(dn_c), 32'd6);
    chk("add_pc",      32'(pc_a), 32'd1);
    chk("add_halted",  32'(st_a), 32'd6);
    chk("add_busy",    32'(busy_a), 32'd0);
`ifdef SEQ_PERF_CNT_EN
    chk("add_cyc_cnt", cyc_a, 32'd6);
    chk("add_ins_cnt", ins_a, 32'd2);
`endif

    // ldm; st; halt
    rom_a[0] = 9'h002; rom_a[1] = 9'h004; rom_a[2] = 9'h01E;
    run_a(30, rf_c, rf_n, re_c, we_c, dn_c, wbs, multi);
    chk("ls_mem_re",   32'(re_c), 32'd4);
    chk("ls_rf_cyc",   32'(rf_c), 32'd5);
    chk("ls_wbsel",    32'(wbs), 32'd1);
    chk("ls_mem_we",   32'(we_c), 32'd9);
    chk("ls_done",     32'(dn_c), 32'd11);
    chk("ls_pc",       32'(pc_a), 32'd2);
    chk("ls_exclusive", 32'(multi), 32'd0);
`ifdef SEQ_PERF_CNT_EN
    chk("ls_cyc_cnt",  cyc_a, 32'd11);
    chk("ls_ins_cnt",  ins_a, 32'd3);
`endif

    // beq taken / not taken, jump ignoring alu_cond
    rom_a[0] = 9'h012; rom_a[1] = 9'h01E; rom_a[16] = 9'h01E;
    tgt_a = 8'h10; cond_a = 1'b1;
    run_a(20, rf_c, rf_n, re_c, we_c, dn_c, wbs, multi);
    chk("beq_t_pc",   32'(pc_a), 32'h10);
    chk("beq_t_done", 32'(dn_c), 32'd5);
    cond_a = 1'b0;
    run_a(20, rf_c, rf_n, re_c, we_c, dn_c, wbs, multi);
    chk("beq_n_pc",   32'(pc_a), 32'h01);
    chk("beq_n_done", 32'(dn_c), 32'd5);
    rom_a[0] = 9'h010;
    run_a(20, rf_c, rf_n, re_c, we_c, dn_c, wbs, multi);
    chk("jmp_pc",     32'(pc_a), 32'h10);
    chk("jmp_rf",     32'(rf_n), 32'd0);

    // PC wrap on B: nop at 4'hF, second start while busy is ignored
    rom_b[15] = 9'h01C; rom_b[0] = 9'h01E;
    @(negedge clk) start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    chk("wrap_fetch_pc", 32'(pc_b), 32'hF);
    @(negedge clk) start_b = 1'b1;
    @(posedge clk); #1 start_b = 1'b0;
    chk("busy_start_st", 32'(st_b), 32'd2);
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("wrap_pc",       32'(pc_b), 32'h0);
    chk("wrap_fetch_st", 32'(st_b), 32'd1);
    @(posedge clk); #1;
    chk("wrap_done",     32'(done_b), 32'd1);
    @(posedge clk); #1;
    chk("wrap_halted",   32'(st_b), 32'd6);

    // reset while a store is in MEM
    rom_a[0] = 9'h004; rom_a[1] = 9'h01E;
    @(negedge clk) start_a = 1'b1;
    @(posedge clk); #1 start_a = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mr_in_mem",   32'(st_a), 32'd4);
    chk("mr_we_pre",   32'(mwe_a), 32'd1);
    reset = 1'b1;
    #1;
    chk("mr_we_rst",   32'(mwe_a), 32'd0);
    @(posedge clk); #1;
    chk("mr_state",    32'(st_a), 32'd0);
    chk("mr_pc",       32'(pc_a), 32'd0);
    chk("mr_busy",     32'(busy_a), 32'd0);
    reset = 1'b0;
    @(posedge clk); #1;

    $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/multicycle_sequencer.md
Name: multicycle_sequencer

Overview:
Multicycle fetch/decode/execute sequencer for the 9-bit-instruction core. It owns the PC and instruction register and steps each instruction through FETCH, DECODE, EXEC, MEM and WB. The decode flags come from the existing Control decoder; this block turns them into per-cycle enables for the register file, data memory and PC. It sits between instruction ROM, Control, the ALU and the register file/data memory.

Parameters:
PC_W, 8, program counter width (ROM depth 2**PC_W)
START_PC, 0, PC value loaded on reset and on start

Ports:
clk  in  1  system clock
reset  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin execution at START_PC (honoured in IDLE/HALTED only)
instr_in  in  9  instruction ROM data at address pc (combinational ROM)
branch_flag  in  1  Control branchFlag for current ir
mem_to_reg  in  1  Control memToRegFlag
mem_write  in  1  Control memWriteFlag
reg_write  in  1  Control regWriteFlag
alu_cond  in  1  ALU compare result (eq/lt/gt per ALUOp), valid in EXEC
branch_target  in  PC_W  target address from datapath, valid in EXEC
pc  out  PC_W  current program counter / ROM address
ir  out  9  latched instruction, feeds Control
ir_load  out  1  high in FETCH
rf_we  out  1  register-file write strobe
mem_we  out  1  data-memory write strobe
mem_re  out  1  data-memory read strobe
wb_sel_mem  out  1  1 = writeback from memory, 0 = from ALU/immediate
busy  out  1  high in every state except IDLE and HALTED
done  out  1  one-cycle pulse on entering HALTED
state_o  out  3  encoded current state, for debug

Behaviour:
- Opcode = ir[4:1]. 0 ldi, 1 ldm, 2 st, 3-7 ALU, 8 jump, 9 beq, 10 blt, 11 bgt, 12 ls, 13 rs, 14 nop, 15 halt.
- States: IDLE=0, FETCH=1, DECODE=2, EXEC=3, MEM=4, WB=5, HALTED=6. Encoding 7 is unused; if reached, go to IDLE next cycle.
- Reset:
  - state=IDLE, pc=START_PC, ir=0.
  - All strobes, busy and done are 0.
  - Reset overrides any state, including mid-instruction; no strobe is asserted in the reset cycle.
- IDLE/HALTED: start -> pc=START_PC, go to FETCH. Otherwise hold.
- FETCH: ir<=instr_in, ir_load=1 -> DECODE.
- DECODE: one cycle for Control to settle.
  - opcode 15 -> HALTED, done=1 for that transition cycle only. pc is not advanced.
  - Otherwise -> EXEC.
- EXEC:
  - Branch/jump (branch_flag=1): jump always taken; beq/blt/bgt taken iff alu_cond. Taken: pc<=branch_target. Not taken: pc<=pc+1. -> FETCH.
  - mem_write or mem_to_reg -> MEM.
  - reg_write -> WB.
  - Otherwise (nop) -> pc<=pc+1, FETCH.
- MEM:
  - Store: mem_we=1, pc<=pc+1 -> FETCH.
  - Load: mem_re=1 -> WB.
- WB: rf_we=1, wb_sel_mem=mem_to_reg, pc<=pc+1 -> FETCH.
- Latencies (cycles per instruction): ldi/ALU/shift 4; ldm 5; st 4; branch/jump/nop 3; halt 2.
- PC arithmetic is modulo 2**PC_W: pc+1 wraps from all-ones to 0 with no flag.
- Strobes are decoded from state only, never registered ahead. At most one of rf_we/mem_we/mem_re is high per cycle.
- A start pulse while busy is ignored.
- Conflicting flags (branch_flag with mem_write or reg_write): branch priority; no memory or register write.

Optional Feature:
SEQ_PERF_CNT_EN:
- Defined: adds outputs cycle_cnt[31:0] and instr_cnt[31:0].
  - cycle_cnt increments every cycle busy=1.
  - instr_cnt increments each time an instruction leaves FETCH.
  - Both clear on reset and on an accepted start; both saturate at all-ones.
- Undefined: ports and logic are absent; all other behaviour is identical.

Decomposition:
- Shared package seq_pkg:
  - state_t enum (3-bit).
  - opcode_t enum (4-bit) with OP_HALT=4'hF and OP_NOP=4'hE.
  - localparam OPC_LSB=1.
- Sub-module seq_perf_counters holds the two saturating counters; it is instantiated only under SEQ_PERF_CNT_EN.

Test Plan:
- Reset mid-operation: reset during MEM of a store -> mem_we=0 that cycle; next cycle state=IDLE, pc=0, busy=0.
- ALU add: ROM[0]=add(9'h006), ROM[1]=halt(9'h01E), start -> rf_we pulses exactly once at cycle 4 after start; done pulses at cycle 6; pc=1 in HALTED.
- Load/store: ROM[0]=ldm(9'h002), ROM[1]=st(9'h004), ROM[2]=halt ->
  - mem_re in cycle 4 and rf_we with wb_sel_mem=1 in cycle 5.
  - mem_we in cycle 9.
  - done at cycle 11.
- Branches:
  - beq with alu_cond=1, branch_target=8'h10 -> pc=8'h10 at next FETCH.
  - Same with alu_cond=0 -> pc=1.
  - jump (9'h010) ignores alu_cond.
- PC wrap with PC_W=4: pc=4'hF on a nop -> pc=0; a start pulse while busy has no effect.
- With SEQ_PERF_CNT_EN: the add+halt program -> instr_cnt=2, cycle_cnt=6 after done.
